// File: rtl/lcd_writer.sv
// HD44780 16x2 character LCD writer: power-up wait, init command sequence,
// then a full two-line refresh (34 bus writes) for every frame request.
`timescale 1ns/1ps

module lcd_writer #(
  parameter int P_PWRUP_CYC = 750000,
  parameter int P_CMD_CYC   = 2500,
  parameter int P_CLR_CYC   = 100000,
  parameter int P_E_CYC     = 25
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [255:0] i_data,
  input  logic         i_start,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_lcd_rs,
  output logic         o_lcd_rw,
  output logic         o_lcd_e,
  output logic [7:0]   o_lcd_data
);

  localparam int MAX_A   = (P_PWRUP_CYC > P_CLR_CYC) ? P_PWRUP_CYC : P_CLR_CYC;
  localparam int MAX_B   = (P_CMD_CYC > P_E_CYC) ? P_CMD_CYC : P_E_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(P_PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(P_CMD_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(P_CLR_CYC - 1);
  localparam logic [CNT_W-1:0] E_LAST     = CNT_W'(P_E_CYC - 1);
  localparam logic [5:0]       INIT_LAST  = 6'd5;
  localparam logic [5:0]       FRAME_LAST = 6'd33;

  typedef enum logic [1:0] {ST_PWRUP, ST_INIT, ST_IDLE, ST_FRAME} top_t;
  typedef enum logic [1:0] {PH_SETUP, PH_EHI, PH_HOLD, PH_WAIT} phase_t;

  top_t             top_reg, top_next;
  phase_t           phase_reg, phase_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [5:0]       widx_reg, widx_next;
  logic [255:0]     snap_reg, snap_next;
  logic             pending_reg, pending_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             e_reg, e_next;
  logic             rs_reg, rs_next;
  logic [7:0]       data_reg, data_next;

  logic             launch;
  logic             begin_frame;
  logic [8:0]       nxt_write;
  logic [5:0]       widx_inc;
  logic [CNT_W-1:0] wait_last;
  logic             seq_last;

  function automatic logic [7:0] init_byte(input logic [5:0] idx);
    case (idx)
      6'd0, 6'd1, 6'd2: init_byte = 8'h38;
      6'd3:             init_byte = 8'h0C;
      6'd4:             init_byte = 8'h01;
      default:          init_byte = 8'h06;
    endcase
  endfunction

  // Returns {rs, byte} for frame write idx: 0x80, chars 0..15, 0xC0, chars 16..31.
  function automatic logic [8:0] frame_write(input logic [5:0] idx, input logic [255:0] snap);
    logic [4:0] cidx;
    cidx = 5'd0;
    frame_write = 9'h080;
    if (idx == 6'd0) begin
      frame_write = 9'h080;
    end else if (idx <= 6'd16) begin
      cidx = 5'(idx - 6'd1);
      frame_write = {1'b1, snap[{cidx, 3'b000} +: 8]};
    end else if (idx == 6'd17) begin
      frame_write = 9'h0C0;
    end else begin
      cidx = 5'(idx - 6'd2);
      frame_write = {1'b1, snap[{cidx, 3'b000} +: 8]};
    end
  endfunction

  // The clear command needs the long settle time; everything else the short one.
  assign wait_last = (data_reg == 8'h01 && !rs_reg) ? CLR_LAST : CMD_LAST;
  assign widx_inc  = widx_reg + 6'd1;
  assign seq_last  = (top_reg == ST_INIT) ? (widx_reg == INIT_LAST) : (widx_reg == FRAME_LAST);

  always_comb begin
    top_next     = top_reg;
    phase_next   = phase_reg;
    cnt_next     = cnt_reg + 1'b1;
    widx_next    = widx_reg;
    snap_next    = snap_reg;
    pending_next = pending_reg | (i_start && (top_reg != ST_IDLE));
    done_next    = 1'b0;
    e_next       = e_reg;
    rs_next      = rs_reg;
    data_next    = data_reg;
    launch       = 1'b0;
    begin_frame  = 1'b0;
    nxt_write    = 9'h000;

    case (top_reg)
      ST_PWRUP: begin
        if (cnt_reg == PWRUP_LAST) begin
          top_next  = ST_INIT;
          widx_next = 6'd0;
          launch    = 1'b1;
          nxt_write = {1'b0, init_byte(6'd0)};
        end
      end
      ST_IDLE: begin
        cnt_next = '0;
        if (i_start) begin
          begin_frame = 1'b1;
        end
      end
      default: begin
        case (phase_reg)
          PH_SETUP: begin
            phase_next = PH_EHI;
            e_next     = 1'b1;
            cnt_next   = '0;
          end
          PH_EHI: begin
            if (cnt_reg == E_LAST) begin
              phase_next = PH_HOLD;
              e_next     = 1'b0;
              cnt_next   = '0;
            end
          end
          PH_HOLD: begin
            if (cnt_reg == E_LAST) begin
              phase_next = PH_WAIT;
              cnt_next   = '0;
            end
          end
          default: begin
            if (cnt_reg == wait_last) begin
              if (seq_last) begin
                done_next = (top_reg == ST_FRAME);
                // A request arriving in this very cycle is treated as pending.
                if (pending_reg || i_start) begin
                  begin_frame = 1'b1;
                end else begin
                  top_next = ST_IDLE;
                end
              end else begin
                widx_next = widx_inc;
                launch    = 1'b1;
                nxt_write = (top_reg == ST_INIT) ? {1'b0, init_byte(widx_inc)}
                                                 : frame_write(widx_inc, snap_reg);
              end
            end
          end
        endcase
      end
    endcase

    if (begin_frame) begin
      top_next     = ST_FRAME;
      widx_next    = 6'd0;
      snap_next    = i_data;
      pending_next = 1'b0;
      launch       = 1'b1;
      nxt_write    = 9'h080;
    end

    // Every write opens with a one-cycle setup: RS/DB change here and then hold.
    if (launch) begin
      phase_next = PH_SETUP;
      cnt_next   = '0;
      e_next     = 1'b0;
      rs_next    = nxt_write[8];
      data_next  = nxt_write[7:0];
    end

    busy_next = (top_next != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      top_reg     <= ST_PWRUP;
      phase_reg   <= PH_SETUP;
      cnt_reg     <= '0;
      widx_reg    <= 6'd0;
      snap_reg    <= '0;
      pending_reg <= 1'b0;
      busy_reg    <= 1'b1;
      done_reg    <= 1'b0;
      e_reg       <= 1'b0;
      rs_reg      <= 1'b0;
      data_reg    <= 8'h00;
    end else begin
      top_reg     <= top_next;
      phase_reg   <= phase_next;
      cnt_reg     <= cnt_next;
      widx_reg    <= widx_next;
      snap_reg    <= snap_next;
      pending_reg <= pending_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      e_reg       <= e_next;
      rs_reg      <= rs_next;
      data_reg    <= data_next;
    end
  end

  assign o_busy     = busy_reg;
  assign o_done     = done_reg;
  assign o_lcd_rs   = rs_reg;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_e    = e_reg;
  assign o_lcd_data = data_reg;

endmodule

// File: tb/tb_lcd_writer.sv
// Bench for lcd_writer: a bus monitor decodes every LCD write and checks it
// against an expected byte stream built from the init list and frame layout.
`timescale 1ns/1ps

module tb_lcd_writer;

  localparam int PWR       = 20;
  localparam int CMD       = 10;
  localparam int CLR       = 30;
  localparam int EC        = 2;
  localparam int WR        = 1 + 2 * EC + CMD;
  localparam int WR_CLR    = 1 + 2 * EC + CLR;
  localparam int INIT_CYC  = PWR + 5 * WR + WR_CLR;
  localparam int FRAME_CYC = 34 * WR;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [255:0] data = '0;
  logic         busy, done, lcd_rs, lcd_rw, lcd_e;
  logic [7:0]   lcd_db;

  always #5 clk = ~clk;

  lcd_writer #(
    .P_PWRUP_CYC(PWR),
    .P_CMD_CYC  (CMD),
    .P_CLR_CYC  (CLR),
    .P_E_CYC    (EC)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_data    (data),
    .i_start   (start),
    .o_busy    (busy),
    .o_done    (done),
    .o_lcd_rs  (lcd_rs),
    .o_lcd_rw  (lcd_rw),
    .o_lcd_e   (lcd_e),
    .o_lcd_data(lcd_db)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected write stream, {rs, byte}, consumed by the monitor in order.
  logic [8:0] exp_q[$];
  int         rise_t[$];
  int         cyc = 0;
  int         n_rises = 0;
  int         n_done = 0;

  task automatic push_init();
    logic [7:0] b[6];
    b = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    foreach (b[i]) exp_q.push_back({1'b0, b[i]});
  endtask

  task automatic push_frame(input logic [255:0] d);
    exp_q.push_back(9'h080);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, d[8*i +: 8]});
    exp_q.push_back(9'h0C0);
    for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, d[8*i +: 8]});
  endtask

  function automatic logic [255:0] rand_frame();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Bus monitor, sampling 1 ns after each rising edge.
  logic       prev_e = 1'b0, prev_rs = 1'b0, want_rise = 1'b0;
  logic [7:0] prev_db = 8'h00;
  int         e_hi = 0;

  always begin : monitor
    logic [8:0] w;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      prev_e = 1'b0; prev_rs = 1'b0; prev_db = 8'h00; want_rise = 1'b0; e_hi = 0;
    end else begin
      if (want_rise) begin
        check("e_rises_after_setup", lcd_e, 1);
        want_rise = 1'b0;
      end
      if (lcd_rs !== prev_rs || lcd_db !== prev_db) begin
        check("db_change_with_e_low", {prev_e, lcd_e}, 0);
        want_rise = 1'b1;
      end
      if (lcd_e && !prev_e) begin
        check("db_stable_at_rise", {prev_rs, prev_db}, {lcd_rs, lcd_db});
        check("rw_low", lcd_rw, 0);
        check("write_in_stream", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("write_value", {lcd_rs, lcd_db}, w);
        end
        rise_t.push_back(cyc);
        n_rises++;
        $display("write %0d at cycle %0d: rs=%0b db=%02h", n_rises, cyc, lcd_rs, lcd_db);
      end
      if (lcd_e) e_hi++;
      if (!lcd_e && prev_e) begin
        check("e_high_width", e_hi, EC);
        e_hi = 0;
      end
      if (done) n_done++;
      prev_e = lcd_e; prev_rs = lcd_rs; prev_db = lcd_db;
    end
  end

  // mode 0: single request; mode 1: extra request in the final wait cycle;
  // mode 2: three requests mid-frame. d2 replaces i_data at cycle m1.
  task automatic frame_run(input logic [255:0] d1, input logic [255:0] d2, input int m1, input int mode);
    int  end_k, done1, done2, nd0, busy_lo;
    bit  rep;
    rep   = (mode != 0);
    end_k = rep ? 2 * FRAME_CYC : FRAME_CYC;
    push_frame(d1);
    if (rep) push_frame(d2);
    nd0 = n_done; done1 = -1; done2 = -1; busy_lo = 0;
    data  = d1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_db", {lcd_rs, lcd_db}, 9'h080);
    check("start_e", lcd_e, 0);
    for (int k = 1; k <= end_k + 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == m1) data = d2;
      if (rep && k == FRAME_CYC + 10) data = rand_frame();
      if (mode == 1 && k == FRAME_CYC - 1) start = 1'b1;
      if (mode == 2 && (k == m1 + 7 || k == m1 + 23 || k == m1 + 61)) start = 1'b1;
      if (done) begin
        if (done1 < 0) done1 = k;
        else if (done2 < 0) done2 = k;
      end
      if (k < end_k && !busy) busy_lo++;
      if (k == end_k) check("busy_after_done", busy, 0);
    end
    check("done_at", done1, FRAME_CYC);
    if (rep) check("redone_at", done2, 2 * FRAME_CYC);
    check("done_count", n_done - nd0, rep ? 2 : 1);
    check("busy_gap", busy_lo, 0);
    check("stream_empty", exp_q.size(), 0);
    $display("frame run mode %0d: done at %0d/%0d", mode, done1, done2);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int           k, nd0, busy_lo, done1, base;
    logic [255:0] d;

    // Reset values and the init sequence.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
    check("rst_e", lcd_e, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_db", lcd_db, 0);
    exp_q.delete();
    rise_t.delete();
    push_init();
    rst = 1'b0;
    k = 0;
    while (!lcd_e && k < 100) begin @(negedge clk); k++; end
    check("first_e_rise", k, PWR + 1);
    while (busy && k < 1000) begin @(negedge clk); k++; end
    check("init_busy_fall", k, INIT_CYC);
    check("init_write_count", rise_t.size(), 6);
    if (rise_t.size() >= 6) begin
      check("gap_after_cmd", rise_t[1] - rise_t[0], WR);
      check("gap_after_clear", rise_t[5] - rise_t[4], WR_CLR);
    end
    check("init_stream_empty", exp_q.size(), 0);
    check("init_no_done", n_done, 0);
    $display("init sequence complete after %0d cycles", k);

    // ASCII frame.
    d = '0;
    for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'h41 + 8'(i);
    for (int i = 0; i < 10; i++) d[8*(16+i) +: 8] = 8'h30 + 8'(i);
    for (int i = 10; i < 16; i++) d[8*(16+i) +: 8] = 8'h61 + 8'(i - 10);
    repeat (3) @(negedge clk);
    frame_run(d, d, -1, 0);

    // Random frames: snapshot isolation, coalesced and late requests.
    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(1, 5)) @(negedge clk);
      frame_run(rand_frame(), rand_frame(), $urandom_range(30, 400), it % 3);
    end

    // Request during INIT starts the frame right after the last init write.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    d = rand_frame();
    push_init();
    push_frame(d);
    nd0 = n_done; busy_lo = 0; done1 = -1;
    rst = 1'b0;
    for (int j = 1; j <= INIT_CYC + FRAME_CYC + 5; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (j == 50) begin data = d; start = 1'b1; end
      if (j == INIT_CYC + 20) data = rand_frame();
      if (done && done1 < 0) done1 = j;
      if (j < INIT_CYC + FRAME_CYC && !busy) busy_lo++;
    end
    check("init_req_done_at", done1, INIT_CYC + FRAME_CYC);
    check("init_req_busy_gap", busy_lo, 0);
    check("init_req_done_count", n_done - nd0, 1);
    check("init_req_stream_empty", exp_q.size(), 0);
    $display("request during init: done at %0d", done1);

    // Reset while E is high in the tenth write of a frame.
    d = rand_frame();
    push_frame(d);
    base = n_rises;
    data = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(n_rises == base + 10 && lcd_e) && k < 1000) begin @(negedge clk); k++; end
    check("reached_write10", n_rises - base, 10);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("midrst_e", lcd_e, 0);
    check("midrst_busy", busy, 1);
    check("midrst_db", lcd_db, 0);
    check("midrst_rs", lcd_rs, 0);
    check("midrst_done", done, 0);
    exp_q.delete();
    push_init();
    rst = 1'b0;
    start = 1'b0;
    nd0 = n_done;
    k = 0;
    while (!lcd_e && k < 100) begin @(negedge clk); k++; end
    check("rerun_first_e", k, PWR + 1);
    while (busy && k < 1000) begin @(negedge clk); k++; end
    check("rerun_busy_fall", k, INIT_CYC);
    repeat (20) @(negedge clk);
    check("rerun_stays_idle", busy, 0);
    check("rerun_no_done", n_done - nd0, 0);
    check("rerun_stream_empty", exp_q.size(), 0);
    $display("reset mid-write: init repeated in %0d cycles", k);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lcd_writer.md
# lcd_writer

Consumes the 256-bit, 32-character frame assembled by the UART byte collector and writes it to the DE0-Nano's HD44780-compatible 16x2 character LCD over an 8-bit parallel bus. After reset it runs the power-up wait and initialisation sequence. It then refreshes both display lines each time a frame-ready pulse arrives. It owns all LCD pin timing (RS, RW, E, DB[7:0]).

## Interface
- P_PWRUP_CYC, 750000: power-up wait before the first command, in cycles (15 ms at 50 MHz).
- P_CMD_CYC, 2500: post-write wait for every command/char except clear (50 µs).
- P_CLR_CYC, 100000: post-write wait after 0x01 clear (2 ms).
- P_E_CYC, 25: E-high width and the following E-low hold, in cycles (500 ns).
- i_clk  in  1  system clock; the only clock.
- i_rst  in  1  reset, synchronous and active-high.
- i_data  in  256  frame; char k (0..31) = i_data[8k+7:8k]; k 0..15 → line 1 col k, k 16..31 → line 2 col k-16.
- i_start  in  1  single-cycle frame-ready pulse.
- o_busy  out  1  high during power-up, init and frame write.
- o_done  out  1  one-cycle pulse when a frame write completes.
- o_lcd_rs  out  1  LCD register select (0 = command, 1 = data).
- o_lcd_rw  out  1  LCD read/write; constant 0.
- o_lcd_e  out  1  LCD enable strobe.
- o_lcd_data  out  8  LCD DB[7:0].

## Operation
- Top states: PWRUP → INIT → IDLE ⇄ FRAME.
- Bus sub-states for every write: SETUP (1 cycle, E=0) → EHI (P_E_CYC cycles, E=1) → HOLD (P_E_CYC cycles, E=0) → WAIT (P_CMD_CYC, or P_CLR_CYC after 0x01).
- RS and DB are driven at SETUP entry and held unchanged through WAIT.
- PWRUP: wait P_PWRUP_CYC cycles, then go to INIT.
- INIT: write commands 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 in order, all with RS=0. Then go to IDLE.
- IDLE: o_busy=0. i_start captures i_data into an internal 256-bit snapshot and enters FRAME.
- FRAME: 34 writes in this order:
  - 0x80 (RS=0);
  - chars 0..15 (RS=1);
  - 0xC0 (RS=0);
  - chars 16..31 (RS=1).
- After the last WAIT: pulse o_done, then go to IDLE, or restart FRAME if a request is pending.
- i_start during PWRUP/INIT/FRAME sets a single pending flag; multiple pulses coalesce into one.
- Pending is serviced at the next IDLE entry: i_data is snapshotted on that cycle and FRAME starts with no idle cycle.
- The snapshot is taken only at frame start. i_data changes during FRAME do not affect the frame in progress.
- Counters: the delay counter is wide enough for max(P_PWRUP_CYC, P_CLR_CYC). Char index is 5 bits and the write index is 6 bits; neither wraps within a frame.

## Timing
- Reset values:
  - state PWRUP, pending=0;
  - o_busy=1, o_done=0;
  - o_lcd_e=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_data=0x00.
- Reset is synchronous and wins over everything. Asserting it mid-write drops E on the next edge and restarts PWRUP; pending and snapshot are discarded.
- Cycles per write: 1 + 2·P_E_CYC + wait.
- i_start sampled high in IDLE at edge N:
  - edge N: o_busy=1, o_lcd_data=0x80;
  - edge N+1: o_lcd_e rises;
  - edge N+1+P_E_CYC: o_lcd_e falls.
- Frame length: 34·(1 + 2·P_E_CYC + P_CMD_CYC) cycles from edge N to o_done high.
- o_done and the IDLE transition occur on the same edge. o_busy falls that edge unless a request is pending.
- i_start coincident with the final WAIT cycle of FRAME counts as pending.
- i_start coincident with i_rst is ignored.
- INIT completion does not pulse o_done.

## Test plan
Parameters for all scenarios: P_PWRUP_CYC=20, P_CMD_CYC=10, P_CLR_CYC=30, P_E_CYC=2.
- Reset then idle → E first rises 21 cycles after reset release. Captured init bytes are 38,38,38,0C,01,06 with RS=0. The gap after 01 is 30 wait cycles. o_busy falls after the last write.
- Frame of ASCII "ABCDEFGHIJKLMNOP" + "0123456789abcdef", one i_start pulse → captured writes are 80, 'A'..'P' (RS=1), C0, '0'..'f'. o_done pulses exactly once, 34·15=510 cycles after i_start.
- i_data changed mid-frame → the displayed bytes equal the snapshot. Three i_start pulses during FRAME → exactly one back-to-back extra frame, carrying the i_data present at restart.
- i_start during INIT → the frame starts immediately after 0x06's wait, with no IDLE cycle.
- i_rst asserted while E is high in write 10 → next edge E=0, busy=1, data=00. The INIT sequence then repeats fully with no o_done.
- Every write → E-high exactly 2 cycles. RS/DB stable from 1 cycle before E rises until wait end. RW is always 0.
